seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Sequencer and arbiter for the 8-digit 7-segment display driver.
//  - Generates the digit scan index and the flash blink phase.
//  - Shares the display between two requesters through valid/ready handshakes.
//  - Holds the displayed data/le/point, updated only on frame boundaries so a frame never tears.
//  - Drives data, le, point, scan and flash of the segment driver directly.
// PARAMETERS
//  SCAN_DIV     16'd50000  clk cycles per digit slot (100 MHz -> 2 kHz digit rate); legal >= 2
//  BLINK_FRAMES 8'd125     full 8-digit frames per flash phase toggle; legal >= 1
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous reset, active low
//  req0_valid in   1   requester 0 has an update
//  req0_data  in   32  requester 0 hex/pixel data
//  req0_le    in   8   requester 0 digit enables
//  req0_point in   8   requester 0 decimal points
//  req0_ready out  1   requester 0 update accepted this cycle
//  req1_*     -    -   identical set for requester 1
//  blink_en   in   1   1: flash toggles; 0: flash held 0
//  data       out  32  displayed data
//  le         out  8   displayed digit enables
//  point      out  8   displayed decimal points
//  scan       out  3   digit index, 0..7
//  flash      out  1   blink phase (1 lights every digit)
//  frame_end  out  1   1-cycle pulse on the last tick of digit 7
//  owner      out  1   requester of the last accepted update
// BEHAVIOUR
//  Reset: scan=0, data=0, le=8'hFF, point=0, flash=0, frame_end=0, owner=0, FSM=IDLE, counters=0.
//  Prescaler: 0..SCAN_DIV-1; tick when count==SCAN_DIV-1, then wraps to 0.
//  - Each tick: scan<=scan+1, 3-bit wrap 7->0.
//  - frame_end registered: asserts one cycle after the tick where scan==7.
//  Blink: frame counter 0..BLINK_FRAMES-1 advances on each frame boundary.
//  - At wrap: flash<=~flash if blink_en.
//  - blink_en=0: flash<=0 and frame counter cleared.
//  Arbiter: grant only in IDLE.
//  - Only one requester valid: that one is granted.
//  - Both valid: the one not equal to owner is granted (round-robin).
//  - reqN_ready = IDLE & grantN (combinational). Transfer when valid&ready.
//  - Requester holds valid/payload stable until ready. At most one transfer per cycle.
//  FSM:
//  - IDLE --transfer--> PEND: payload captured into shadow regs, owner<=granted index.
//  - PEND --frame boundary (tick & scan==7)--> IDLE: shadow copied to data/le/point.
//  - New data is visible from the scan==0 slot onward.
//  - Transfer in the same cycle as a boundary: captured; commits at the NEXT boundary, not this one.
//  - While in PEND both readies are 0; requests stall until commit.
//  Reset mid-operation: shadow discarded, outputs return to reset values, scan restarts at 0.
// CONFIGURATION
//  SEG_FRAME_SYNC_EN defined: commit on frame boundary as above; latency <= 8*SCAN_DIV+1 cycles.
//  SEG_FRAME_SYNC_EN undefined: PEND lasts exactly one cycle.
//  - Shadow commits on the cycle after transfer regardless of scan.
//  - Ready recovers the following cycle. Scan and blink are unchanged.
// TESTING (SCAN_DIV=4, BLINK_FRAMES=2, SEG_FRAME_SYNC_EN defined unless noted)
//  1 Release rst_n, idle 64 cycles
//    -> scan steps 0..7 every 4 clks, wraps.
//    -> frame_end pulses every 32 clks.
//    -> data=0, le=FF.
//  2 req0 data=32'h1234_5678 le=FF point=01 at scan=3
//    -> ready same cycle.
//    -> data unchanged until the scan 7->0 wrap, then 12345678.
//    -> owner=0.
//  3 req0 and req1 valid together, owner=0
//    -> req1 granted first.
//    -> req0 stalled (ready=0) until commit, then granted.
//    -> data shows req1 payload, then req0 payload.
//  4 blink_en=1 for 8 frames
//    -> flash toggles every 2 frames: 0,0,1,1,0,0,1,1.
//    -> blink_en=0 -> flash=0 next cycle.
//  5 Transfer at the boundary cycle
//    -> commit deferred one full frame (32 clks).
//    -> rst_n low while in PEND -> data=0, le=FF, readies reappear after release.
//  6 SEG_FRAME_SYNC_EN undefined
//    -> data updates 2 clks after transfer at any scan.
//    -> back-to-back requests accepted every 2 clks.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan sequencer, blink generator and two-requester update arbiter
// for an 8-digit 7-segment display driver.
// Optional feature macro: SEG_FRAME_SYNC_EN
//   defined   - an accepted update commits to data/le/point on the next frame
//               boundary (last tick of digit 7), so a frame never tears.
//   undefined - an accepted update commits on the cycle after it is accepted.
module seg_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [7:0]  BLINK_FRAMES = 8'd125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [7:0]  req0_le,
    input  logic [7:0]  req0_point,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [7:0]  req1_le,
    input  logic [7:0]  req1_point,
    output logic        req1_ready,
    input  logic        blink_en,
    output logic [31:0] data,
    output logic [7:0]  le,
    output logic [7:0]  point,
    output logic [2:0]  scan,
    output logic        flash,
    output logic        frame_end,
    output logic        owner
);

    localparam logic [15:0] DivLast   = SCAN_DIV - 16'd1;
    localparam logic [7:0]  FrameLast = BLINK_FRAMES - 8'd1;

    typedef enum logic {StIdle, StPend} state_e;

    // Scan and blink state
    logic [15:0] r_div_cnt;
    logic [2:0]  r_scan;
    logic        r_frame_end;
    logic [7:0]  r_frame_cnt;
    logic        r_flash;

    // Update path state
    state_e      r_state;
    logic [31:0] r_shd_data;
    logic [7:0]  r_shd_le;
    logic [7:0]  r_shd_point;
    logic [31:0] r_data;
    logic [7:0]  r_le;
    logic [7:0]  r_point;
    logic        r_owner;

    logic        w_tick;
    logic        w_boundary;
    logic        w_frame_wrap;
    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_xfer;
    logic        w_commit;
    logic [31:0] w_pl_data;
    logic [7:0]  w_pl_le;
    logic [7:0]  w_pl_point;

    // Slot tick, frame boundary and blink-frame wrap decode
    always_comb begin
        w_tick       = (r_div_cnt == DivLast);
        w_boundary   = w_tick && (r_scan == 3'd7);
        w_frame_wrap = (r_frame_cnt == FrameLast);
    end

    // Round-robin grant: with both requesters valid, favour the one that did not win last
    always_comb begin
        w_idle     = (r_state == StIdle);
        w_grant1   = req1_valid && (!req0_valid || !r_owner);
        w_grant0   = req0_valid && (!req1_valid || r_owner);
        req0_ready = w_idle && w_grant0;
        req1_ready = w_idle && w_grant1;
        w_xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        w_pl_data  = w_grant1 ? req1_data  : req0_data;
        w_pl_le    = w_grant1 ? req1_le    : req0_le;
        w_pl_point = w_grant1 ? req1_point : req0_point;
    end

    // Commit condition for a pending update
    always_comb begin
`ifdef SEG_FRAME_SYNC_EN
        w_commit = (r_state == StPend) && w_boundary;
`else
        w_commit = (r_state == StPend);
`endif
    end

    // Prescaler, digit scan index and registered frame-end pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= 16'd0;
            r_scan      <= 3'd0;
            r_frame_end <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= 16'd0;
                r_scan    <= r_scan + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            r_frame_end <= w_boundary;
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frames, held low and restarted when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
            r_flash     <= 1'b0;
        end else if (!blink_en) begin
            r_frame_cnt <= 8'd0;
            r_flash     <= 1'b0;
        end else if (w_boundary) begin
            if (w_frame_wrap) begin
                r_frame_cnt <= 8'd0;
                r_flash     <= ~r_flash;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Update FSM: capture granted payload into shadow, then commit it to the display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_shd_data  <= 32'd0;
            r_shd_le    <= 8'hFF;
            r_shd_point <= 8'd0;
            r_data      <= 32'd0;
            r_le        <= 8'hFF;
            r_point     <= 8'd0;
            r_owner     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A capture on a boundary cycle waits for the following boundary
                    if (w_xfer) begin
                        r_shd_data  <= w_pl_data;
                        r_shd_le    <= w_pl_le;
                        r_shd_point <= w_pl_point;
                        r_owner     <= w_grant1;
                        r_state     <= StPend;
                    end
                end
                StPend: begin
                    if (w_commit) begin
                        r_data  <= r_shd_data;
                        r_le    <= r_shd_le;
                        r_point <= r_shd_point;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign data      = r_data;
    assign le        = r_le;
    assign point     = r_point;
    assign scan      = r_scan;
    assign flash     = r_flash;
    assign frame_end = r_frame_end;
    assign owner     = r_owner;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=4, BLINK_FRAMES=2).
// Accepted updates are pushed to a scoreboard with the edge on which they must
// become visible; a monitor pops and compares whenever data/le/point change.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam logic [15:0] SCAN_DIV     = 16'd4;
    localparam logic [7:0]  BLINK_FRAMES = 8'd2;
    localparam int unsigned SLOT         = 4;
    localparam int unsigned FRAME        = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic [7:0]  req0_le, req1_le, req0_point, req1_point;
    logic        req0_ready, req1_ready;
    logic        blink_en;
    logic [31:0] data;
    logic [7:0]  le, point;
    logic [2:0]  scan;
    logic        flash, frame_end, owner;

    seg_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_le   (req0_le),
        .req0_point(req0_point),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_le   (req1_le),
        .req1_point(req1_point),
        .req1_ready(req1_ready),
        .blink_en  (blink_en),
        .data      (data),
        .le        (le),
        .point     (point),
        .scan      (scan),
        .flash     (flash),
        .frame_end (frame_end),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [47:0] pl;
        int unsigned at_k;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    // Rising edges since reset release
    int unsigned k;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned commit_edge(input int unsigned kt);
`ifdef SEG_FRAME_SYNC_EN
        return (kt / FRAME + 1) * FRAME;
`else
        return kt + 1;
`endif
    endfunction

    task automatic push(input logic [47:0] pl, input int unsigned kt);
        sb_t e;
        e.pl   = pl;
        e.at_k = commit_edge(kt);
        sb_q.push_back(e);
    endtask

    // Display monitor: every change of data/le/point must match the scoreboard head
    logic [47:0] prev_pl;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pl <= {32'h0, 8'hFF, 8'h00};
        end else if ({data, le, point} !== prev_pl) begin
            prev_pl <= {data, le, point};
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", {16'h0, data, le, point}, {16'h0, prev_pl});
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("commit_payload", {16'h0, data, le, point}, {16'h0, mon_e.pl});
                check_eq("commit_edge", 64'(k), 64'(mon_e.at_k));
`ifdef SEG_FRAME_SYNC_EN
                check_eq("commit_scan", 64'(scan), 64'd0);
`endif
            end
        end
    end

    // Drive one request from a negedge until accepted; returns whether ready was up at once
    task automatic send(input logic idx, input logic [31:0] d, input logic [7:0] l,
                        input logic [7:0] p, output logic first_rdy);
        logic rdy;
        int   n;
        if (idx) begin
            req1_valid = 1'b1; req1_data = d; req1_le = l; req1_point = p;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_le = l; req0_point = p;
        end
        #1;
        rdy = idx ? req1_ready : req0_ready;
        first_rdy = rdy;
        n = 0;
        while (!rdy && n < 400) begin
            @(negedge clk);
            #1;
            rdy = idx ? req1_ready : req0_ready;
            n++;
        end
        if (!rdy) check_eq("send_timeout", 64'(rdy), 64'd1);
        else      push({d, l, p}, k + 1);
        @(posedge clk);
        @(negedge clk);
        if (idx) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_k_mod(input int unsigned m);
        int n;
        n = 0;
        while ((k % FRAME) != m && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        fr;
        logic [7:0]  pat;
        int unsigned kt, c1, prev_kt;
        int          n;

        req0_valid = 1'b0; req0_data = '0; req0_le = '0; req0_point = '0;
        req1_valid = 1'b0; req1_data = '0; req1_le = '0; req1_point = '0;
        blink_en   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_data", 64'(data), 64'h0);
        check_eq("rst_le", 64'(le), 64'hFF);
        check_eq("rst_point", 64'(point), 64'h0);
        check_eq("rst_scan", 64'(scan), 64'h0);
        check_eq("rst_flash", 64'(flash), 64'h0);
        check_eq("rst_frame_end", 64'(frame_end), 64'h0);
        check_eq("rst_owner", 64'(owner), 64'h0);
        #1 rst_n = 1'b1;

        // 1: free-running scan and frame_end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check_eq("t1_scan", 64'(scan), 64'((k / SLOT) % 8));
            check_eq("t1_frame_end", 64'(frame_end), 64'((k % FRAME) == 0));
        end
        check_eq("t1_data", 64'(data), 64'h0);
        check_eq("t1_le", 64'(le), 64'hFF);

        // 2: single request from req0 in slot 3
        wait_k_mod(3 * SLOT);
        send(1'b0, 32'h1234_5678, 8'hFF, 8'h01, fr);
        check_eq("t2_ready_same_cycle", 64'(fr), 64'd1);
        wait_drain();
        check_eq("t2_data", 64'(data), 64'h1234_5678);
        check_eq("t2_owner", 64'(owner), 64'd0);

        // 3: both valid with owner=0 -> req1 first, req0 stalls until commit
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'hAAAA_0000; req0_le = 8'h0F; req0_point = 8'h10;
        req1_valid = 1'b1; req1_data = 32'hBBBB_1111; req1_le = 8'hF0; req1_point = 8'h20;
        #1;
        check_eq("t3_req1_ready", 64'(req1_ready), 64'd1);
        check_eq("t3_req0_ready", 64'(req0_ready), 64'd0);
        kt = k + 1;
        c1 = commit_edge(kt);
        push({req1_data, req1_le, req1_point}, kt);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check_eq("t3_owner1", 64'(owner), 64'd1);
        check_eq("t3_req0_stall", 64'(req0_ready), 64'd0);
        n = 0;
        while (!req0_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("t3_req0_grant_at", 64'(k), 64'(c1));
        push({req0_data, req0_le, req0_point}, k + 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check_eq("t3_owner0", 64'(owner), 64'd0);
        wait_drain();

        // 4: blink over 8 frames, then disable
        pat = 8'hCC;
        @(negedge clk);
        wait_k_mod(0);
        blink_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("t4_flash", 64'(flash), 64'(pat[i]));
            if (i != 7) repeat (FRAME) @(negedge clk);
        end
        blink_en = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t4_flash_off", 64'(flash), 64'd0);

        // 5: transfer on the boundary edge, then reset while pending
        @(negedge clk);
        wait_k_mod(FRAME - 1);
        send(1'b0, 32'hCAFE_F00D, 8'h3C, 8'h81, fr);
        check_eq("t5_ready", 64'(fr), 64'd1);
        wait_drain();
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 32'hDEAD_BEEF; req1_le = 8'h55; req1_point = 8'hAA;
        #1;
        check_eq("t5_req1_ready", 64'(req1_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check_eq("t5_owner1", 64'(owner), 64'd1);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_eq("t5_rst_data", 64'(data), 64'h0);
        check_eq("t5_rst_le", 64'(le), 64'hFF);
        check_eq("t5_rst_point", 64'(point), 64'h0);
        check_eq("t5_rst_owner", 64'(owner), 64'h0);
        check_eq("t5_rst_scan", 64'(scan), 64'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, 32'h0BAD_CAFE, 8'hC3, 8'h42, fr);
        check_eq("t5_ready_after_rst", 64'(fr), 64'd1);
        wait_drain();
        check_eq("t5_data_after_rst", 64'(data), 64'h0BAD_CAFE);

`ifndef SEG_FRAME_SYNC_EN
        // 6: immediate commit, back-to-back acceptance every 2 clocks
        @(negedge clk);
        prev_kt = 0;
        for (int j = 0; j < 4; j++) begin
            req0_valid = 1'b1;
            req0_data  = 32'h6000_0000 + 32'(j);
            req0_le    = 8'(j + 1);
            req0_point = 8'(8'h80 >> j);
            #1;
            n = 0;
            while (!req0_ready && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            kt = k + 1;
            if (j > 0) check_eq("t6_spacing", 64'(kt - prev_kt), 64'd2);
            prev_kt = kt;
            push({req0_data, req0_le, req0_point}, kt);
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        wait_drain();
`endif

        repeat (4) @(negedge clk);
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
